// File: rtl/ods_feed_ctrl.sv
// Feed sequencer for the three-row output data shifter: steers words into rows, fires a shift per group.
// Optional stall counter enabled by defining ODS_FEED_PERF_EN.
module ods_feed_ctrl #(
  parameter int IO_DATA_WIDTH = 16,
  parameter int GRP_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     start,
  input  logic [GRP_CNT_WIDTH-1:0] cfg_num_groups,
  input  logic [IO_DATA_WIDTH-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [IO_DATA_WIDTH-1:0] ods_in,
  output logic [1:0]               ods_sel_out,
  output logic                     ods_shift,
  input  logic                     ds_ready,
  output logic                     grp_valid,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              perf_stall_cycles
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [1:0]               row_cnt_q, row_cnt_d;
  logic [GRP_CNT_WIDTH-1:0] grp_cnt_q, grp_cnt_d;
  logic [GRP_CNT_WIDTH-1:0] num_q, num_d;
  logic                     grp_valid_q, grp_valid_d;
  logic                     accept;
  logic                     start_acc;

  assign start_acc   = (state_q == ST_IDLE) && start;
  assign in_ready    = (state_q == ST_LOAD);
  assign accept      = in_ready && in_valid;
  assign ods_in      = in_data;
  assign ods_sel_out = accept ? row_cnt_q : 2'b11;
  assign ods_shift   = (state_q == ST_SHIFT) && ds_ready;
  assign grp_valid   = grp_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    grp_cnt_d   = grp_cnt_q;
    num_d       = num_q;
    grp_valid_d = ods_shift;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d     = cfg_num_groups;
          grp_cnt_d = '0;
          row_cnt_d = 2'd0;
          state_d   = (cfg_num_groups != '0) ? ST_LOAD : ST_FIN;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (row_cnt_q == 2'd2) begin
            row_cnt_d = 2'd0;
            state_d   = ST_SHIFT;
          end else begin
            row_cnt_d = row_cnt_q + 2'd1;
          end
        end
      end
      ST_SHIFT: begin
        // Full-width compare so an all-ones group count terminates without wrapping
        if (ds_ready) begin
          grp_cnt_d = grp_cnt_q + GRP_CNT_WIDTH'(1);
          state_d   = (grp_cnt_d == num_q) ? ST_FIN : ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= 2'd0;
      grp_cnt_q   <= '0;
      num_q       <= '0;
      grp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      grp_cnt_q   <= grp_cnt_d;
      num_q       <= num_d;
      grp_valid_q <= grp_valid_d;
    end
  end

`ifdef ODS_FEED_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        stall;

  assign stall = ((state_q == ST_LOAD) && !in_valid) || ((state_q == ST_SHIFT) && !ds_ready);

  always_comb begin
    perf_d = perf_q;
    if (start_acc) begin
      perf_d = '0;
    end else if (stall && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  logic unused_start_acc;
  assign unused_start_acc  = start_acc;
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ods_feed_ctrl.sv
// Randomized scoreboard bench for ods_feed_ctrl; a job-level model predicts phases, writes and pulses.
// Define ODS_FEED_PERF_EN to also check the stall counter.
module tb_ods_feed_ctrl;

  localparam int DW = 16;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          arst_n_in = 1'b0;
  logic          start = 1'b0;
  logic [GW-1:0] cfg_num_groups = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          ds_ready = 1'b0;
  logic          in_ready;
  logic [DW-1:0] ods_in;
  logic [1:0]    ods_sel_out;
  logic          ods_shift;
  logic          grp_valid;
  logic          busy;
  logic          done;
  logic [31:0]   perf_stall_cycles;

  ods_feed_ctrl #(.IO_DATA_WIDTH(DW), .GRP_CNT_WIDTH(GW)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .cfg_num_groups(cfg_num_groups),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .ods_in(ods_in),
    .ods_sel_out(ods_sel_out), .ods_shift(ods_shift), .ds_ready(ds_ready),
    .grp_valid(grp_valid), .busy(busy), .done(done), .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard: words offered upstream, popped in order as the model predicts accepts
  logic [DW-1:0] word_q[$];
  bit            job_active = 1'b0;
  int unsigned   job_num = 0;
  int unsigned   words_seen = 0;
  int unsigned   shifts_seen = 0;
  bit            prev_exp_shift = 1'b0;
  longint unsigned perf_model = 0;
  bit            ds_mode = 1'b0;

  task automatic checkOutput(input string name, input longint unsigned actual, input longint unsigned expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Job-level model: which phase the job is in follows from words and groups completed so far
  always @(negedge clk) begin : monitor
    bit loading, shifting, fin, exp_shift, acc, was_active;
    logic [DW-1:0] d;
    if (!arst_n_in) begin
      job_active     = 1'b0;
      words_seen     = 0;
      shifts_seen    = 0;
      prev_exp_shift = 1'b0;
      perf_model     = 0;
      word_q.delete();
    end else begin
      was_active = job_active;
      loading   = job_active && (words_seen < 3 * job_num) && (words_seen < 3 * (shifts_seen + 1));
      shifting  = job_active && (shifts_seen < job_num) && (words_seen == 3 * (shifts_seen + 1));
      fin       = job_active && !loading && !shifting;
      exp_shift = shifting && ds_ready;
      acc       = loading && in_valid;
      checkOutput("in_ready", 64'(in_ready), 64'(loading));
      checkOutput("busy", 64'(busy), 64'(job_active));
      checkOutput("done", 64'(done), 64'(fin));
      checkOutput("grp_valid", 64'(grp_valid), 64'(prev_exp_shift));
      checkOutput("ods_shift", 64'(ods_shift), 64'(exp_shift));
      if (acc) begin
        checkOutput("scoreboard_nonempty", 64'(word_q.size() > 0), 64'd1);
        d = (word_q.size() > 0) ? word_q.pop_front() : '0;
        checkOutput("ods_sel_out", 64'(ods_sel_out), 64'(words_seen % 3));
        checkOutput("ods_in", 64'(ods_in), 64'(d));
        words_seen++;
      end else begin
        checkOutput("ods_sel_out_idle", 64'(ods_sel_out), 64'd3);
      end
`ifdef ODS_FEED_PERF_EN
      checkOutput("perf_stall_cycles", 64'(perf_stall_cycles), perf_model);
      if (((loading && !in_valid) || (shifting && !ds_ready)) && perf_model < 64'hFFFF_FFFF)
        perf_model++;
`else
      checkOutput("perf_stall_cycles", 64'(perf_stall_cycles), 64'd0);
`endif
      if (exp_shift) shifts_seen++;
      prev_exp_shift = exp_shift;
      if (fin) job_active = 1'b0;
      if (start && !was_active) begin
        job_active  = 1'b1;
        job_num     = 32'(cfg_num_groups);
        words_seen  = 0;
        shifts_seen = 0;
        perf_model  = 0;
      end
    end
  end

  // Random downstream backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ds_mode) ds_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic waitIdle();
    for (int c = 0; c < 2000 && job_active; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("idle_timeout", 64'(job_active), 64'd0);
  endtask

  task automatic startJob(input int unsigned num);
    start = 1'b1;
    cfg_num_groups = GW'(num);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic feedWords(input int unsigned n, input int gap_pct, input int first_gap);
    logic [DW-1:0] d;
    bit accepted;
    for (int i = 0; i < int'(n); i++) begin
      if ((i == 1 && first_gap > 0) || ($urandom_range(0, 99) < gap_pct)) begin
        in_valid = 1'b0;
        repeat ((i == 1 && first_gap > 0) ? first_gap : int'($urandom_range(1, 3))) @(posedge clk);
        #1;
      end
      d = DW'($urandom);
      word_q.push_back(d);
      in_data  = d;
      in_valid = 1'b1;
      accepted = 1'b0;
      for (int c = 0; c < 500 && !accepted; c++) begin
        @(negedge clk);
        accepted = in_ready;
        @(posedge clk);
        #1;
      end
      checkOutput("accept_timeout", 64'(accepted), 64'd1);
      if (!accepted) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int unsigned num, input int gap_pct, input int first_gap, input bit ds_rand);
    ds_mode = ds_rand;
    if (!ds_rand) ds_ready = 1'b1;
    waitIdle();
    startJob(num);
    feedWords(3 * num, gap_pct, first_gap);
    waitIdle();
  endtask

  task automatic checkResetValues();
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_ods_sel_out", 64'(ods_sel_out), 64'd3);
    checkOutput("rst_ods_shift", 64'(ods_shift), 64'd0);
    checkOutput("rst_grp_valid", 64'(grp_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_perf", 64'(perf_stall_cycles), 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkResetValues();
    arst_n_in = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1, 0, 0, 1'b0);
    applyStimulus(3, 0, 0, 1'b0);
    applyStimulus(1, 0, 2, 1'b0);

    // Hold off downstream for five shift cycles; a stray start meanwhile must be ignored
    ds_mode  = 1'b0;
    ds_ready = 1'b0;
    startJob(1);
    feedWords(3, 0, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    ds_ready = 1'b1;
    waitIdle();
`ifdef ODS_FEED_PERF_EN
    checkOutput("perf_five_stalls", 64'(perf_stall_cycles), 64'd5);
`endif

    applyStimulus(0, 0, 0, 1'b0);

    // Abandon a job after two accepts
    startJob(1);
    feedWords(2, 0, 0);
    arst_n_in = 1'b0;
    #1;
    checkResetValues();
    @(posedge clk);
    #1;
    arst_n_in = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 0, 0, 1'b0);

    for (int j = 0; j < 20; j++) begin
      applyStimulus(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6), 30, 0, 1'b1);
    end

    ds_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
